// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the decode-stage register file and its pending-write scoreboard.
// Control, forwarding and the register file import these so they agree on r0 and default sizes.
package regfile_scoreboard_pkg;

  localparam int REG_ZERO      = 0;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREG_DEFAULT  = 32;
  localparam int NREAD_DEFAULT = 2;
  localparam int CNT_W_DEFAULT = 2;

  // Largest number of writes that may be in flight to one register.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One pending-write counter: saturating up/down with zero and max flags.
// Simultaneous inc and dec cancel, so a producer issuing while another retires keeps the count.
module regfile_scoreboard_sb_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             max_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign max_o  = (cnt_q == '1);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register pending-write
// scoreboard that stalls issue on any in-flight producer or on counter overflow.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREG  = NREG_DEFAULT,
  parameter int NREAD = NREAD_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic [NREAD-1:0]      rd_en_i,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  input  logic                  issue_valid_i,
  input  logic                  issue_wb_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam logic [AW-1:0]    ADDR_ZERO = AW'(REG_ZERO);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]  pend_zero;
  logic [NREG-1:0]  pend_max;
  logic [NREAD-1:0] src_hazard;
  logic             ovf_hazard;
  logic             issue_accept;
  logic             wr_real;
  logic             err_q;
  logic             err_d;

  assign wr_real = wr_en_i && (wr_addr_i != ADDR_ZERO);

  // Data array: r0 is never written, so it stays at its reset value of zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr_real) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Read ports: bypass the writeback value so a retiring producer can release its consumer.
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
    logic [AW-1:0] addr;
    logic          bypass_hit;

    assign addr       = rd_addr_i[gi*AW +: AW];
    assign bypass_hit = wr_en_i && (wr_addr_i == addr);

    assign rd_data_o[gi*XLEN +: XLEN] = (addr == ADDR_ZERO) ? '0 :
                                        bypass_hit          ? wr_data_i :
                                                              regs_q[addr];

    // pend_zero[0] is tied high, which also covers the r0 exemption.
    assign src_hazard[gi] = rd_en_i[gi] && !pend_zero[addr] &&
                            !(bypass_hit && (pend_cnt[addr] == CNT_ONE));
  end

  assign ovf_hazard = issue_wb_i && pend_max[issue_rd_i] &&
                      !(wr_en_i && (wr_addr_i == issue_rd_i));

  assign stall_o      = issue_valid_i && ((|src_hazard) || ovf_hazard);
  assign issue_accept = issue_valid_i && !stall_o && issue_wb_i && (issue_rd_i != ADDR_ZERO);

  // r0 never has a producer in flight.
  assign pend_cnt[0]  = '0;
  assign pend_zero[0] = 1'b1;
  assign pend_max[0]  = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = issue_accept && (issue_rd_i == AW'(gi));
    assign dec = wr_en_i && (wr_addr_i == AW'(gi)) && !pend_zero[gi];

    regfile_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .n_rst_i (n_rst_i),
      .inc_i   (inc),
      .dec_i   (dec),
      .cnt_o   (pend_cnt[gi]),
      .zero_o  (pend_zero[gi]),
      .max_o   (pend_max[gi])
    );
  end

  // A writeback is legitimate only if a producer is pending, or is being issued this same cycle.
  always_comb begin
    err_d = err_q;
    if (wr_real && pend_zero[wr_addr_i] &&
        !(issue_accept && (issue_rd_i == wr_addr_i))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file and load-use hazard check.
- Provides NREAD combinational read ports with write-through bypass and one posedge write port.
- Keeps a per-register pending-write scoreboard, so stalls are generated for any in-flight producer of any latency, not only a load in EX.
- Sits in ID. Issue comes from the decode control path; writeback comes from WB.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of 2, >=2); register 0 reads as zero.
- NREAD, 2, number of read ports.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2^CNT_W-1.
- Derived (localparam): AW = $clog2(NREG).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- n_rst_i  in  1  asynchronous active-low reset.
- rd_en_i  in  NREAD  per-port read-enable (source used by the instruction in ID).
- rd_addr_i  in  NREAD*AW  packed read addresses, port k at [k*AW +: AW].
- rd_data_o  out  NREAD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
- issue_valid_i  in  1  instruction in ID wants to leave ID this cycle.
- issue_wb_i  in  1  that instruction writes a register.
- issue_rd_i  in  AW  destination register of that instruction.
- wr_en_i  in  1  WB write strobe.
- wr_addr_i  in  AW  WB destination.
- wr_data_i  in  XLEN  WB data.
- stall_o  out  1  hold IF/ID and insert a bubble into ID/EX.
- err_o  out  1  sticky: writeback to a register with zero pending count.

Behaviour:
- Reset (n_rst_i low, asynchronous): all NREG registers = 0, all pending counters = 0, err_o = 0. stall_o then depends only on the live inputs.
- Read, combinational, per port k:
  - addr==0 -> 0.
  - Else if wr_en_i && wr_addr_i==addr -> wr_data_i (same-cycle bypass).
  - Else -> regs[addr].
- Write, posedge: if wr_en_i && wr_addr_i!=0, regs[wr_addr_i] <= wr_data_i. Writes to r0 are discarded.
- src_hazard(k) = rd_en_i[k] && addr_k!=0 && pend[addr_k]!=0, unless the bypass completes the last producer: wr_en_i && wr_addr_i==addr_k && pend[addr_k]==1.
- ovf_hazard = issue_wb_i && issue_rd_i!=0 && pend[issue_rd_i]==max, unless wr_en_i && wr_addr_i==issue_rd_i this cycle.
- stall_o = issue_valid_i && (OR of src_hazard over all k || ovf_hazard). Combinational, zero latency.
- Accepted issue = issue_valid_i && !stall_o && issue_wb_i && issue_rd_i!=0.
- Counter update, posedge, per register r:
  - inc = accepted issue to r.
  - dec = wr_en_i && wr_addr_i==r && r!=0 && pend[r]!=0.
  - inc&dec -> unchanged; inc -> +1; dec -> -1.
  - Counters never wrap: the overflow stall guarantees this.
- Error: wr_en_i && wr_addr_i!=0 && pend[wr_addr_i]==0 && !inc for that register -> err_o <= 1. err_o stays set until reset. The data write still happens.
- r0 is never pending. Issue to r0 and write to r0 are ignored by the scoreboard.
- Multiple read ports on the same address behave independently and identically.
- No flush input. Squashed instructions must be dropped before issue, because issue is the commit point for the scoreboard.

Decomposition:
- Shared package/header: MEM_NONE-style encodings are not needed here. Add `REG_ZERO (0) and the default XLEN/NREG to header.v so the control unit and forwarding logic agree.
- Natural sub-module: sb_counter (one CNT_W saturating up/down counter with inc/dec/zero/max flags), generated NREG-1 times.
- The data array and bypass mux stay in the top level.

Test Plan:
- Reset: drive n_rst_i low mid-run with regs written -> every rd_data_o = 0, stall_o = 0 with issue_valid_i=0, err_o = 0.
- Load-use: issue rd=5 (accepted), next cycle read port0 addr 5 en=1, issue_valid_i=1 -> stall_o=1 until the cycle wr_en_i=1, wr_addr_i=5, wr_data_i=0xDEADBEEF. In that cycle stall_o=0 and rd_data_o port0 = 0xDEADBEEF.
- Two in flight: issue rd=7 twice, one write to 7 -> reading 7 still stalls (pend=1). Second write -> no stall. Port1 disabled (rd_en_i[1]=0) on addr 7 never stalls.
- Overflow, CNT_W=2: issue rd=3 three times, then a fourth issue with no write -> stall_o=1 and pend stays 3. Same fourth issue alongside wr_addr_i=3 -> accepted, pend stays 3.
- r0: issue rd=0, read addr 0, write 0x1234 to r0 -> no stall, reads 0, err_o=0.
- Spurious writeback: write r9 with pend=0 -> err_o=1 next cycle, regs[9] updated, err_o held until reset.
